drive_multi_ch_ctrl_gen: RTL
============================

# drive_multi_ch_ctrl_gen

Multi-channel drive control signal generator for the Horse Ridge–style drive circuit. It produces one registered `update_pc` pulse per channel whenever a fetch condition occurs. A fetch condition is a rising edge of the shared envelope-read-finished flag, a per-channel trigger, or a per-channel RZ-finished flag. It adds two behaviours per channel: a fetch-busy window, and a saturating pending-event counter, so that events arriving while a fetch is in flight are replayed rather than lost. It sits between the global envelope-memory sequencer and the per-qubit program counters.

## Interface
- `NUM_CH`, 8: number of drive channels (≥1).
- `FETCH_LAT`, 2: busy-window length in cycles after each `update_pc` pulse (≥1).
- `PEND_W`, 2: width of the per-channel pending counter. It saturates at 2^PEND_W−1.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `glb_is_read_env_fin` input 1: shared level flag. Only its rising edge counts as an event.
- `trigger` input NUM_CH: per-channel trigger, level sampled each cycle.
- `is_rz_fin` input NUM_CH: per-channel RZ-finished, level sampled each cycle.
- `ch_en` input NUM_CH: per-channel enable.
- `clr_ovf` input 1: synchronous clear of all `pend_ovf` bits.
- `update_pc` output NUM_CH: registered one-cycle fetch pulse.
- `busy` output NUM_CH: registered, high during the channel's fetch window.
- `pend_ovf` output NUM_CH: registered, sticky, set when an event is dropped at saturation.

## Operation
- **Global edge detect:**
  - `prev_glb` is a register and resets to 0.
  - `glb_rise = glb_is_read_env_fin & ~prev_glb`.
  - A flag that is already high in the first cycle after reset release counts as one rising edge.
- **Per-channel event:** `ev[i] = ch_en[i] & (glb_rise | trigger[i] | is_rz_fin[i])`.
  - Any combination of sources in the same cycle counts as one event.
- **Per-channel FSM states:** IDLE and FETCH. Each channel also has a down-counter `cnt` of width clog2(FETCH_LAT), min 1, and the counter `pend` of PEND_W bits.
- **IDLE:**
  - If `ev` is high, or `pend>0` with `ch_en` high: `update_pc<=1`, go to FETCH, `cnt<=FETCH_LAT−1`.
  - If the issue was taken from `pend` (no `ev`), `pend` decrements.
- **FETCH with `cnt>0`:**
  - `update_pc<=0`, `cnt` decrements.
  - Each `ev` increments `pend`.
- **FETCH with `cnt==0` (last busy cycle):**
  - If `ev` is high, or `pend>0` with `ch_en` high: `update_pc<=1`, stay in FETCH, reload `cnt`.
  - The issued request is the oldest, so `pend` decrements by 1 and increments by 1 if `ev` is high. The net update uses this same-cycle inc/dec rule.
  - Otherwise go to IDLE.
- **Saturation:** an increment at `pend==2^PEND_W−1` leaves `pend` unchanged and sets `pend_ovf[i]`.
- **`ch_en[i]` low:**
  - Events are masked.
  - `pend` is cleared on the next edge.
  - No new pulses are issued.
  - A FETCH window already running completes and the channel returns to IDLE.
- **`clr_ovf`:** clears all `pend_ovf` bits. If a set and `clr_ovf` occur in the same cycle, the set wins.
- **Independence:** channels are fully independent apart from the shared `glb_rise` and `clr_ovf`.

## Timing
- **Reset (`rst`=0, asynchronous):**
  - `update_pc=0`, `busy=0`, `pend_ovf=0`.
  - `pend=0`, `cnt=0`, state IDLE, `prev_glb=0`.
  - A mid-window reset aborts the window and discards all pending events.
- **Latency:** event in cycle t gives `update_pc` high in cycle t+1 only, with `busy` high in cycles t+1 … t+FETCH_LAT.
- **Pulse spacing:**
  - Back-to-back issues are spaced exactly FETCH_LAT cycles apart.
  - With FETCH_LAT=1, a pulse can occur every cycle.
- **Held inputs:**
  - A held-high `trigger` or `is_rz_fin` is one event per cycle. It therefore accumulates `pend` during FETCH.
  - A held-high `glb_is_read_env_fin` is a single event.
- **Reaction time:** `pend_ovf` sets in the cycle after the dropped event.

## Test plan
- **Reset:** NUM_CH=8, FETCH_LAT=2, PEND_W=2; assert `rst`=0 asynchronously mid-cycle -> all outputs 0 immediately, and they stay 0 after release while inputs are idle.
- **Single trigger:** `trigger[3]` pulsed one cycle at t -> `update_pc[3]` high at t+1 only, `busy[3]` high at t+1 and t+2, all other channels quiet.
- **Global edge:** hold `glb_is_read_env_fin` high for 10 cycles with `ch_en`=8'hFF -> exactly one `update_pc` pulse on all 8 channels, in the same cycle.
- **Pending replay:** on ch0, trigger at t, then at t+1 and t+2 -> pulses at t+1, t+3, t+5; `pend` returns to 0; `busy` is continuous from t+1 to t+6.
- **Saturation:** hold `is_rz_fin[1]` high for 8 cycles with PEND_W=2 -> `pend` reaches 3, `pend_ovf[1]`=1, pulses continue every 2 cycles until the backlog drains; then `clr_ovf` -> `pend_ovf[1]`=0.
- **Disable mid-backlog:** ch2 with `pend`=2, drop `ch_en[2]` -> no further pulses, `pend` cleared, `busy[2]` falls at the end of the current window; re-enable -> no spurious pulse.

Source files
------------

// File: rtl/drive_multi_ch_ctrl_gen.sv
// Multi-channel drive control generator: per-channel update_pc pulses with a
// fetch-busy window and a saturating pending-event counter for replay.
module drive_multi_ch_ctrl_gen #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned FETCH_LAT = 2,
    parameter int unsigned PEND_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              glb_is_read_env_fin,
    input  logic [NUM_CH-1:0] trigger,
    input  logic [NUM_CH-1:0] is_rz_fin,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              clr_ovf,
    output logic [NUM_CH-1:0] update_pc,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] pend_ovf
);

    localparam int unsigned       CW         = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
    localparam logic [CW-1:0]     CNT_RELOAD = CW'(FETCH_LAT - 1);
    localparam logic [PEND_W-1:0] PEND_MAX   = '1;

    typedef enum logic {IDLE, FETCH} state_t;

    logic prev_glb;
    logic glb_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_glb <= 1'b0;
        else      prev_glb <= glb_is_read_env_fin;
    end

    assign glb_rise = glb_is_read_env_fin & ~prev_glb;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t            state_q, state_d;
        logic [CW-1:0]     cnt_q, cnt_d;
        logic [PEND_W-1:0] pend_q, pend_d;
        logic              upd_q, upd_d;
        logic              busy_q;
        logic              ovf_q, ovf_set;
        logic              ev, issue, has_pend;

        assign ev       = ch_en[i] & (glb_rise | trigger[i] | is_rz_fin[i]);
        assign has_pend = (pend_q != '0);
        assign issue    = ev | (has_pend & ch_en[i]);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pend_d  = pend_q;
            upd_d   = 1'b0;
            ovf_set = 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        upd_d   = 1'b1;
                        state_d = FETCH;
                        cnt_d   = CNT_RELOAD;
                        if (!ev) pend_d = pend_q - 1'b1;
                    end
                end
                FETCH: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        if (ev) begin
                            if (pend_q == PEND_MAX) ovf_set = 1'b1;
                            else                    pend_d  = pend_q + 1'b1;
                        end
                    end else if (issue) begin
                        // Oldest request issues first: a same-cycle event
                        // replaces it in pend, so pend only drops without ev.
                        upd_d = 1'b1;
                        cnt_d = CNT_RELOAD;
                        if (has_pend && !ev) pend_d = pend_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (!ch_en[i]) pend_d = '0;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                pend_q  <= '0;
                upd_q   <= 1'b0;
                busy_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
                upd_q   <= upd_d;
                busy_q  <= (state_d == FETCH);
                ovf_q   <= ovf_set | (ovf_q & ~clr_ovf);
            end
        end

        assign update_pc[i] = upd_q;
        assign busy[i]      = busy_q;
        assign pend_ovf[i]  = ovf_q;
    end

endmodule
